// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file with scoreboard.
package regfile_pkg;

    // Register index that is hardwired to zero and never tracked as pending.
    localparam int ZERO_REG = 0;

    // Address width for a register array of the given depth (at least one bit).
    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard: issue sets, writeback clears, issue wins a tie.
// Keeps a running count of pending registers and reports per-read-port readiness.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int AW     = addrWidth(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_addr,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_ready,
    output logic [AW:0]          pending_cnt
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

    logic [DEPTH-1:0] pendQ, pendD;
    logic [AW:0]      cntQ, cntD, riseCnt, fallCnt;

    // Next pending vector: writebacks clear first, then an issue overrides them.
    always_comb begin
        pendD = pendQ;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                pendD[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en && (issue_addr != ZERO_ADDR)) begin
            pendD[issue_addr] = 1'b1;
        end
    end

    // Counter delta from bit transitions so the count never needs a full recount.
    always_comb begin
        riseCnt = '0;
        fallCnt = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (pendD[r] && !pendQ[r]) riseCnt = riseCnt + CNT_ONE;
            if (!pendD[r] && pendQ[r]) fallCnt = fallCnt + CNT_ONE;
        end
        cntD = cntQ + riseCnt - fallCnt;
    end

    // Pending bits and count share one edge so they always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendQ <= '0;
            cntQ  <= '0;
        end else begin
            pendQ <= pendD;
            cntQ  <= cntD;
        end
    end

    // Readiness lookup from registered state; r0 is never pending so it reads ready.
    always_comb begin
        rd_ready = '1;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_ready[k] = ~pendQ[rd_addr[k*AW +: AW]];
        end
    end

    assign pending_cnt = cntQ;

endmodule

// File: rtl/regfile_multiport_sb.sv
// Parametrised multi-read/multi-write register file with hardwired zero register
// and a pending scoreboard. Optional write-through bypass: define REGFILE_BYPASS_EN.
module regfile_multiport_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 32,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 2,
    localparam int AW     = addrWidth(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [AW:0]              pending_cnt
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [DATA_W-1:0] regsQ [DEPTH];
    logic [NUM_RD-1:0] sbReady;

    rf_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .AW     (AW)
    ) uScoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .rd_ready    (sbReady),
        .pending_cnt (pending_cnt)
    );

    // Array writes; ports are visited in ascending order so the higher port wins a clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regsQ[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != ZERO_ADDR)) begin
                    regsQ[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Combinational read ports, optionally forwarding same-cycle write data.
    always_comb begin
        rd_data  = '0;
        rd_ready = sbReady;
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_addr[k*AW +: AW] != ZERO_ADDR) begin
                rd_data[k*DATA_W +: DATA_W] = regsQ[rd_addr[k*AW +: AW]];
            end
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed in reset so outputs read as cleared state.
            for (int j = 0; j < NUM_WR; j++) begin
                if (!rst && wr_en[j] && (rd_addr[k*AW +: AW] != ZERO_ADDR) &&
                    (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])) begin
                    rd_data[k*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                    rd_ready[k]                 = 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Self-checking bench for regfile_multiport_sb (default parameters).
// A behavioural model is compared against the DUT every negedge, with literal spot checks.
module tb_regfile_multiport_sb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]      rd_ready;
    logic            issue_en;
    logic [AW-1:0]   issue_addr;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [AW:0]     pending_cnt;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    regfile_multiport_sb dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] mReg  [32];
    bit          mPend [32];

    function automatic int wa(input int j);
        return int'(wr_addr[j*AW +: AW]);
    endfunction

    function automatic int ra(input int k);
        return int'(rd_addr[k*AW +: AW]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                mReg[r]  = 32'h0;
                mPend[r] = 1'b0;
            end
        end else begin
            // Writebacks commit data and retire the producer; the later port's data stands.
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j]) begin
                    if (wa(j) != 0) mReg[wa(j)] = wr_data[j*DW +: DW];
                    mPend[wa(j)] = 1'b0;
                end
            end
            // A new producer is always in flight after issue, even if written this cycle.
            if (issue_en && issue_addr != 0) mPend[int'(issue_addr)] = 1'b1;
        end
    end

    function automatic int expCnt();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(mPend[r]);
        return n;
    endfunction

    function automatic logic [31:0] expData(input int k);
        logic [31:0] v;
        v = (ra(k) == 0) ? 32'h0 : mReg[ra(k)];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < 2; j++)
            if (!rst && wr_en[j] && wa(j) == ra(k) && ra(k) != 0) v = wr_data[j*DW +: DW];
`endif
        return v;
    endfunction

    function automatic logic expReady(input int k);
        logic r;
        r = ~mPend[ra(k)];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < 2; j++)
            if (!rst && wr_en[j] && wa(j) == ra(k) && ra(k) != 0) r = 1'b1;
`endif
        return r;
    endfunction

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rd_data[k*DW +: DW] !== expData(k)) begin
                    errors++;
                    $display("FAIL cmp rd_data[%0d] addr=%0d got=%h exp=%h t=%0t",
                             k, ra(k), rd_data[k*DW +: DW], expData(k), $time);
                end
                checks++;
                if (rd_ready[k] !== expReady(k)) begin
                    errors++;
                    $display("FAIL cmp rd_ready[%0d] addr=%0d got=%b exp=%b t=%0t",
                             k, ra(k), rd_ready[k], expReady(k), $time);
                end
            end
            checks++;
            if (int'(pending_cnt) != expCnt()) begin
                errors++;
                $display("FAIL cmp pending_cnt got=%0d exp=%0d t=%0t",
                         pending_cnt, expCnt(), $time);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        issue_en = 1'b0;
        wr_en    = 2'b00;
    endtask

    task automatic setWr(input int j, input int a, input logic [31:0] d);
        wr_en[j]            = 1'b1;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*DW +: DW] = d;
    endtask

    task automatic setRd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic issue(input int a);
        issue_en   = 1'b1;
        issue_addr = AW'(a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        rd_addr = '0; issue_addr = '0; wr_addr = '0; wr_data = '0;
        idle();
        #1;
        chk("reset rd_data", {32'h0, rd_data}, 64'h0);
        chk("reset rd_ready", {62'h0, rd_ready}, 64'h3);
        chk("reset pending_cnt", {58'h0, pending_cnt}, 64'h0);
        #11 rst = 1'b0;
        run = 1'b1;

        // Write r5 and issue r8, then an asynchronous reset mid-cycle.
        setWr(0, 5, 32'hDEADBEEF); issue(8);
        tick(); idle(); setRd(0, 5);
        #1;
        chk("r5 written", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
        chk("cnt after issue r8", {58'h0, pending_cnt}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midreset r5", {32'h0, rd_data[31:0]}, 64'h0);
        chk("midreset ready", {62'h0, rd_ready}, 64'h3);
        chk("midreset cnt", {58'h0, pending_cnt}, 64'h0);
        #3 rst = 1'b0;
        tick();

        // Zero register ignores writes and issues.
        setWr(0, 0, 32'h1234); issue(0); setRd(0, 0);
        tick(); idle();
        #1;
        chk("r0 data", {32'h0, rd_data[31:0]}, 64'h0);
        chk("r0 ready", {63'h0, rd_ready[0]}, 64'h1);
        chk("r0 issue cnt", {58'h0, pending_cnt}, 64'h0);

        // Same-address dual write: port 1 wins.
        setWr(0, 7, 32'hAAAA_AAAA); setWr(1, 7, 32'h5555_5555);
        tick(); idle(); setRd(1, 7);
        #1;
        chk("dual write r7", {32'h0, rd_data[63:32]}, 64'h5555_5555);

        // Scoreboard set then clear.
        issue(3);
        tick(); idle(); setRd(0, 3);
        #1;
        chk("r3 pending ready", {63'h0, rd_ready[0]}, 64'h0);
        chk("r3 pending cnt", {58'h0, pending_cnt}, 64'd1);
        setWr(0, 3, 32'h42);
        tick(); idle();
        #1;
        chk("r3 ready", {63'h0, rd_ready[0]}, 64'h1);
        chk("r3 data", {32'h0, rd_data[31:0]}, 64'h42);
        chk("r3 cnt", {58'h0, pending_cnt}, 64'd0);

        // Issue and writeback of the same register: data lands, still pending.
        issue(9);
        tick(); idle();
        issue(9); setWr(0, 9, 32'h10);
        tick(); idle(); setRd(0, 9);
        #1;
        chk("r9 data", {32'h0, rd_data[31:0]}, 64'h10);
        chk("r9 still pending", {63'h0, rd_ready[0]}, 64'h0);
        chk("r9 cnt", {58'h0, pending_cnt}, 64'd1);

        // Issue r4 while retiring r2: count holds.
        issue(2);
        tick(); idle();
        issue(4); setWr(1, 2, 32'h22);
        tick(); idle(); setRd(0, 4); setRd(1, 2);
        #1;
        chk("issue+retire cnt", {58'h0, pending_cnt}, 64'd2);
        chk("r4 pending", {63'h0, rd_ready[0]}, 64'h0);
        chk("r2 data", {32'h0, rd_data[63:32]}, 64'h22);

        // Same-cycle write and read of a pending register.
        issue(6);
        tick(); idle();
        setWr(0, 6, 32'h77); setRd(0, 6);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass data", {32'h0, rd_data[31:0]}, 64'h77);
        chk("bypass ready", {63'h0, rd_ready[0]}, 64'h1);
`else
        chk("nobypass data", {32'h0, rd_data[31:0]}, 64'h0);
        chk("nobypass ready", {63'h0, rd_ready[0]}, 64'h0);
`endif
        tick(); idle();
        #1;
        chk("after write r6 data", {32'h0, rd_data[31:0]}, 64'h77);
        chk("after write r6 ready", {63'h0, rd_ready[0]}, 64'h1);

        // Two retirements in one cycle (r9, r4).
        setWr(0, 9, 32'h99); setWr(1, 4, 32'h44);
        tick(); idle();
        #1;
        chk("double retire cnt", {58'h0, pending_cnt}, 64'd0);

        // Fill every register, then drain two per cycle while reads wander.
        for (int r = 1; r < 32; r++) begin
            issue(r); setRd(1, $urandom_range(0, 31));
            tick();
        end
        idle(); issue(0);
        tick(); idle();
        #1;
        chk("full cnt", {58'h0, pending_cnt}, 64'd31);
        for (int r = 1; r < 32; r += 2) begin
            setWr(0, r, 32'h0101_0101 * r);
            if (r + 1 < 32) setWr(1, r + 1, 32'h0101_0101 * (r + 1));
            setRd(0, r); setRd(1, $urandom_range(0, 31));
            tick(); idle();
        end
        setRd(0, 31);
        #1;
        chk("drained cnt", {58'h0, pending_cnt}, 64'd0);
        chk("r31 data", {32'h0, rd_data[31:0]}, 64'h1F1F_1F1F);

        tick(); tick();
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
